// File: rtl/ufm_reader.sv
// rtl/ufm_reader.sv - streams UFM flash page bytes through the MachXO EFB Wishbone port.
// Define UFM_READER_AUTOINC_EN to keep reading consecutive pages until rst.
module ufm_reader (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [13:0] start_page,
   input  logic        stb,
   output logic [7:0]  data,
   output logic        data_valid,
   output logic        busy,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [7:0]  wb_adr_o,
   output logic [7:0]  wb_dat_o,
   input  logic [7:0]  wb_dat_i,
   input  logic        wb_ack_i
);

   typedef enum logic [2:0] {
      S_IDLE, S_ENABLE, S_SETADDR, S_READCMD, S_WAIT_REQ, S_READ_BYTE, S_CLOSE
   } state_t;

   localparam logic [7:0] CFGCR   = 8'h70;
   localparam logic [7:0] CFGTXDR = 8'h71;
   localparam logic [7:0] CFGRXDR = 8'h73;

   state_t      state_q, state_d;
   logic [3:0]  step_q, step_d;
   logic [3:0]  byte_cnt_q, byte_cnt_d;
   logic [13:0] page_q, page_d;
   logic        pend_q, pend_d;
   logic        cyc_q, cyc_d;
   logic        we_q, we_d;
   logic        busy_q, busy_d;
   logic        data_valid_q, data_valid_d;
   logic [7:0]  adr_q, adr_d;
   logic [7:0]  dat_o_q, dat_o_d;
   logic [7:0]  data_q, data_d;

   logic [7:0]  op_adr, op_dat;
   logic        op_last;

   // Register write performed at each step of the command-frame states.
   always_comb begin
      op_adr  = CFGTXDR;
      op_dat  = 8'h00;
      op_last = 1'b0;
      case (state_q)
         S_ENABLE: begin
            case (step_q)
               4'd0:    op_adr = CFGCR;
               4'd1:    begin op_adr = CFGCR; op_dat = 8'h80; end
               4'd2:    op_dat = 8'h74;
               4'd3:    op_dat = 8'h08;
               4'd4:    op_dat = 8'h00;
               4'd5:    op_dat = 8'h00;
               default: begin op_adr = CFGCR; op_last = 1'b1; end
            endcase
         end
         S_SETADDR: begin
            case (step_q)
               4'd0:    begin op_adr = CFGCR; op_dat = 8'h80; end
               4'd1:    op_dat = 8'hB4;
               4'd5:    op_dat = 8'h40;
               4'd7:    op_dat = {2'b00, page_q[13:8]};
               4'd8:    op_dat = page_q[7:0];
               4'd9:    begin op_adr = CFGCR; op_last = 1'b1; end
               default: op_dat = 8'h00;
            endcase
         end
         S_READCMD: begin
            case (step_q)
               4'd0:    begin op_adr = CFGCR; op_dat = 8'h80; end
               4'd1:    op_dat = 8'hCA;
               4'd2:    op_dat = 8'h00;
               4'd3:    op_dat = 8'h00;
               default: begin op_dat = 8'h01; op_last = 1'b1; end
            endcase
         end
         default: begin
            op_adr  = CFGCR;
            op_last = 1'b1;
         end
      endcase
   end

   always_comb begin
      state_d      = state_q;
      step_d       = step_q;
      byte_cnt_d   = byte_cnt_q;
      page_d       = page_q;
      pend_d       = pend_q;
      cyc_d        = cyc_q;
      we_d         = we_q;
      adr_d        = adr_q;
      dat_o_d      = dat_o_q;
      data_d       = data_q;
      data_valid_d = 1'b0;

      // Requests arriving while no read frame is ready are remembered, not dropped.
      case (state_q)
         S_IDLE, S_ENABLE, S_SETADDR, S_READCMD, S_CLOSE:
            if (stb && !data_valid_q) pend_d = 1'b1;
         default: ;
      endcase

      case (state_q)
         S_IDLE: begin
            if (start) begin
               page_d  = start_page;
               step_d  = 4'd0;
               state_d = S_ENABLE;
            end
         end
         S_WAIT_REQ: begin
            if ((stb || pend_q) && !data_valid_q) begin
               pend_d  = 1'b0;
               cyc_d   = 1'b1;
               we_d    = 1'b0;
               adr_d   = CFGRXDR;
               state_d = S_READ_BYTE;
            end
         end
         S_READ_BYTE: begin
            if (wb_ack_i) begin
               cyc_d        = 1'b0;
               data_d       = wb_dat_i;
               data_valid_d = 1'b1;
               byte_cnt_d   = byte_cnt_q + 4'd1;
               if (byte_cnt_q == 4'd15) begin
                  page_d  = page_q + 14'd1;
                  step_d  = 4'd0;
                  state_d = S_CLOSE;
               end else begin
                  state_d = S_WAIT_REQ;
               end
            end
         end
         default: begin
            if (!cyc_q) begin
               cyc_d   = 1'b1;
               we_d    = 1'b1;
               adr_d   = op_adr;
               dat_o_d = op_dat;
            end else if (wb_ack_i) begin
               cyc_d = 1'b0;
               we_d  = 1'b0;
               if (!op_last) begin
                  step_d = step_q + 4'd1;
               end else begin
                  step_d = 4'd0;
                  case (state_q)
                     S_ENABLE:  state_d = S_SETADDR;
                     S_SETADDR: state_d = S_READCMD;
                     S_READCMD: begin
                        byte_cnt_d = 4'd0;
                        state_d    = S_WAIT_REQ;
                     end
`ifdef UFM_READER_AUTOINC_EN
                     default:   state_d = S_READCMD;
`else
                     default:   state_d = S_IDLE;
`endif
                  endcase
               end
            end
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // Reset drops any open bus cycle without a close write.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         step_q       <= 4'd0;
         byte_cnt_q   <= 4'd0;
         page_q       <= 14'd0;
         pend_q       <= 1'b0;
         cyc_q        <= 1'b0;
         we_q         <= 1'b0;
         busy_q       <= 1'b0;
         adr_q        <= 8'h00;
         dat_o_q      <= 8'h00;
         data_q       <= 8'h00;
         data_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         step_q       <= step_d;
         byte_cnt_q   <= byte_cnt_d;
         page_q       <= page_d;
         pend_q       <= pend_d;
         cyc_q        <= cyc_d;
         we_q         <= we_d;
         busy_q       <= busy_d;
         adr_q        <= adr_d;
         dat_o_q      <= dat_o_d;
         data_q       <= data_d;
         data_valid_q <= data_valid_d;
      end
   end

   assign data       = data_q;
   assign data_valid = data_valid_q;
   assign busy       = busy_q;
   assign wb_cyc_o   = cyc_q;
   assign wb_stb_o   = cyc_q;
   assign wb_we_o    = we_q;
   assign wb_adr_o   = adr_q;
   assign wb_dat_o   = dat_o_q;

endmodule

// File: tb/tb_ufm_reader.sv
// tb/tb_ufm_reader.sv - scoreboard bench for ufm_reader against a behavioural EFB/UFM model.
module tb_ufm_reader;

   logic        clk = 1'b0;
   logic        rst, start, stb;
   logic [13:0] start_page;
   logic [7:0]  data;
   logic        data_valid, busy;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic [7:0]  wb_adr_o, wb_dat_o, wb_dat_i;
   logic        wb_ack_i;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [7:0]  sb[$];
   logic [15:0] wlog[$];
   logic [15:0] exp_w[$];

   int          min_delay = 0;
   int          max_delay = 1;
   int          cnt = 0;
   logic [13:0] mpage = 14'd0;
   logic [3:0]  midx = 4'd0;
   logic [7:0]  frame [8];
   int          fcnt = 0;
   int          b4_count = 0;
   int          dv_count = 0;
   logic        prev_dv = 1'b0;

   ufm_reader dut (
      .clk(clk), .rst(rst), .start(start), .start_page(start_page), .stb(stb),
      .data(data), .data_valid(data_valid), .busy(busy),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // EFB model: random wait states, logs writes, decodes the B4 address command.
   initial begin
      wb_ack_i = 1'b0;
      wb_dat_i = 8'h00;
   end

   always @(negedge clk) begin
      if (rst || !wb_cyc_o) begin
         wb_ack_i = 1'b0;
         cnt = int'($urandom_range(max_delay, min_delay));
      end else if (wb_ack_i) begin
         wb_ack_i = 1'b0;
      end else if (cnt > 0) begin
         cnt--;
      end else begin
         wb_ack_i = 1'b1;
         if (wb_we_o) begin
            wlog.push_back({wb_adr_o, wb_dat_o});
            if (wb_adr_o == 8'h70) begin
               fcnt = 0;
            end else if (wb_adr_o == 8'h71 && fcnt < 8) begin
               frame[fcnt] = wb_dat_o;
               fcnt++;
               if (fcnt == 8 && frame[0] == 8'hB4) begin
                  mpage = {frame[6][5:0], frame[7]};
                  midx = 4'd0;
                  b4_count++;
               end
            end
         end else begin
            wb_dat_i = {mpage[3:0], midx};
            midx++;
            if (midx == 4'd0) mpage++;
         end
      end
   end

   always @(negedge clk) begin
      if (data_valid === 1'b1) begin
         dv_count++;
         check("dv_gap", 32'(prev_dv), 32'h0);
         check("dv_expected", 32'(sb.size() != 0), 32'h1);
         if (sb.size() != 0) check("data", 32'(data), 32'(sb.pop_front()));
      end
      prev_dv = (data_valid === 1'b1);
   end

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      start = 1'b0;
      stb = 1'b0;
      tick;
      tick;
      rst = 1'b0;
   endtask

   task automatic do_start(input logic [13:0] p);
      wlog.delete();
      start_page = p;
      start = 1'b1;
      tick;
      start = 1'b0;
   endtask

   task automatic wait_writes(input int n);
      int t = 0;
      while (wlog.size() < n && t < 3000) begin
         tick;
         t++;
      end
      if (wlog.size() < n) check("wr_timeout", 32'(wlog.size()), 32'(n));
   endtask

   task automatic wait_drain;
      int t = 0;
      while (sb.size() != 0 && t < 200) begin
         tick;
         t++;
      end
      if (sb.size() != 0) check("rd_timeout", 32'(sb.size()), 32'h0);
   endtask

   task automatic req(input logic [7:0] e);
      sb.push_back(e);
      stb = 1'b1;
      tick;
      stb = 1'b0;
      wait_drain;
      tick;
   endtask

   task automatic build_exp(input logic [13:0] p);
      exp_w.delete();
      exp_w = '{16'h7000, 16'h7080, 16'h7174, 16'h7108, 16'h7100, 16'h7100, 16'h7000,
                16'h7080, 16'h71B4, 16'h7100, 16'h7100, 16'h7100, 16'h7140, 16'h7100};
      exp_w.push_back({8'h71, 2'b00, p[13:8]});
      exp_w.push_back({8'h71, p[7:0]});
      exp_w.push_back(16'h7000);
      exp_w.push_back(16'h7080);
      exp_w.push_back(16'h71CA);
      exp_w.push_back(16'h7100);
      exp_w.push_back(16'h7100);
      exp_w.push_back(16'h7101);
   endtask

   initial begin
      int base, t, n;
      logic [13:0] pg;
      rst = 1'b1;
      start = 1'b0;
      stb = 1'b0;
      start_page = 14'd0;

      do_reset;
      check("rst_data", 32'(data), 32'h0);
      check("rst_dv", 32'(data_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_cyc", 32'(wb_cyc_o), 32'h0);
      check("rst_stb", 32'(wb_stb_o), 32'h0);
      check("rst_we", 32'(wb_we_o), 32'h0);
      check("rst_adr", 32'(wb_adr_o), 32'h0);
      check("rst_dat", 32'(wb_dat_o), 32'h0);

      // Page 2: command sequence, then spaced single requests.
      max_delay = 1;
      do_start(14'h0002);
      check("busy_start", 32'(busy), 32'h1);
      wait_writes(22);
      build_exp(14'h0002);
      for (int i = 0; i < 22; i++)
         if (i < wlog.size()) check($sformatf("wr%0d", i), 32'(wlog[i]), 32'(exp_w[i]));
      repeat (3) tick;
      base = dv_count;
      for (int i = 0; i < 16; i++) begin
         sb.push_back(8'h20 + 8'(i));
         stb = 1'b1;
         tick;
         stb = 1'b0;
         repeat (3) tick;
      end
      wait_drain;
      check("spaced_dv_count", 32'(dv_count - base), 32'd16);
      wait_writes(23);
      if (wlog.size() >= 23) check("close_wr", 32'(wlog[22]), 32'h7000);
      repeat (6) tick;
`ifdef UFM_READER_AUTOINC_EN
      check("busy_after_page", 32'(busy), 32'h1);
`else
      check("busy_after_page", 32'(busy), 32'h0);
`endif

      // Page 3: stb held high for a whole page.
      max_delay = 3;
      do_reset;
      do_start(14'h0003);
      wait_writes(22);
      repeat (3) tick;
      base = dv_count;
      for (int i = 0; i < 16; i++) sb.push_back(8'h30 + 8'(i));
      stb = 1'b1;
      t = 0;
      while (dv_count - base < 16 && t < 500) begin
         tick;
         t++;
      end
      stb = 1'b0;
      repeat (30) tick;
      check("held_dv_count", 32'(dv_count - base), 32'd16);

      // Last page, wrap behaviour.
      do_reset;
      b4_count = 0;
      do_start(14'h3FFF);
      wait_writes(22);
      repeat (3) tick;
`ifdef UFM_READER_AUTOINC_EN
      pg = 14'h3FFF;
      for (int i = 0; i < 32; i++) begin
         req({pg[3:0], 4'(i)});
         if (i == 15) pg = pg + 14'd1;
      end
`else
      for (int i = 0; i < 16; i++) req({4'hF, 4'(i)});
      wait_writes(23);
      if (wlog.size() >= 23) check("close_wr_last", 32'(wlog[22]), 32'h7000);
      repeat (5) tick;
      check("busy_idle", 32'(busy), 32'h0);
      base = dv_count;
      repeat (3) begin
         stb = 1'b1;
         tick;
         stb = 1'b0;
         repeat (5) tick;
      end
      repeat (20) tick;
      check("idle_no_dv", 32'(dv_count - base), 32'h0);
`endif
      check("b4_count", 32'(b4_count), 32'h1);

      // Reset with a read cycle outstanding.
      do_reset;
      min_delay = 3;
      max_delay = 3;
      do_start(14'h0005);
      wait_writes(22);
      repeat (3) tick;
      stb = 1'b1;
      tick;
      stb = 1'b0;
      t = 0;
      while (!(wb_cyc_o && !wb_we_o) && t < 50) begin
         tick;
         t++;
      end
      check("rd_issued", 32'(wb_cyc_o && !wb_we_o), 32'h1);
      rst = 1'b1;
      tick;
      check("abort_cyc", 32'(wb_cyc_o), 32'h0);
      check("abort_dv", 32'(data_valid), 32'h0);
      check("abort_busy", 32'(busy), 32'h0);
      rst = 1'b0;
      repeat (10) tick;

      min_delay = 2;
      max_delay = 2;
      do_start(14'h0001);
      wait_writes(22);
      repeat (3) tick;
      sb.push_back(8'h10);
      stb = 1'b1;
      n = 0;
      do begin
         tick;
         stb = 1'b0;
         n++;
      end while (sb.size() != 0 && n < 50);
      check("latency", 32'(n), 32'd4);
      check("after_abort_data", 32'(data), 32'h10);
      repeat (5) tick;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ufm_reader.md
UFM_READER -- requirements
Module: ufm_reader

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-002 SHALL have: start  in  1  pulse, load start_page and begin a read session.
REQ-003 SHALL have: start_page  in  14  UFM page index for the session.
REQ-004 SHALL have: stb  in  1  downstream (page_buffer seq_stb) request for next byte.
REQ-005 SHALL have: data  out  8  byte delivered; data_valid  out  1  one-cycle qualifier for data.
REQ-006 SHALL have: busy  out  1  session active (not IDLE).
REQ-007 SHALL have EFB Wishbone master: wb_cyc_o, wb_stb_o, wb_we_o out 1; wb_adr_o out 8; wb_dat_o out 8; wb_dat_i in 8; wb_ack_i in 1.

Function
REQ-008 SHALL use single classic Wishbone cycles: cyc=stb held until wb_ack_i, one byte each, deasserted the cycle after ack, at most one cycle outstanding.
REQ-009 SHALL address EFB registers CFGCR=0x70, CFGTXDR=0x71, CFGRXDR=0x73; "open" = write 0x80 to CFGCR, "close" = write 0x00 to CFGCR.
REQ-010 SHALL run states IDLE -> ENABLE -> SETADDR -> READCMD -> WAIT_REQ <-> READ_BYTE -> CLOSE -> IDLE.
REQ-011 ENABLE: close, open, TXDR 0x74,0x08,0x00,0x00, close (leading close terminates any stale frame).
REQ-012 SETADDR: open, TXDR 0xB4,0x00,0x00,0x00,0x40,0x00,{2'b0,page[13:8]},page[7:0], close.
REQ-013 READCMD: open, TXDR 0xCA,0x00,0x00,0x01; frame stays open; byte counter cleared.
REQ-014 WAIT_REQ: a request is accepted when stb=1; READ_BYTE then reads CFGRXDR once.
REQ-015 On read ack: data <= wb_dat_i, data_valid=1 next cycle for exactly one cycle; accepted-stb to data_valid latency = Wishbone wait + 2 cycles.
REQ-016 stb is ignored in READ_BYTE and in the data_valid cycle; a still-high stb is accepted from the following cycle.
REQ-017 Byte counter 4 bits; after the 16th byte of a page: close, then CLOSE behaviour per REQ-026.
REQ-018 start while busy=1 SHALL be ignored; start in IDLE latches start_page.
REQ-019 stb while IDLE or in ENABLE/SETADDR/READCMD SHALL be held as pending and served on entering WAIT_REQ.
REQ-020 data SHALL hold last delivered value when data_valid=0.
REQ-021 Page counter 14 bits, increments per completed page, wraps 0x3FFF -> 0x0000.

Reset
REQ-022 rst SHALL force IDLE within one cycle, aborting any Wishbone cycle (cyc/stb/we low next edge).
REQ-023 Reset values: data=0x00, data_valid=0, busy=0, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=0x00, wb_dat_o=0x00, counters=0, pending=0.
REQ-024 Reset mid-frame SHALL NOT emit any close write; the next session's ENABLE leading close covers it.

Configuration
REQ-025 Macro UFM_READER_AUTOINC_EN selects page auto-increment.
REQ-026 Defined: after a page closes, go to READCMD directly (no SETADDR; flash address auto-advances), session continues until rst. Undefined: after a page closes, go to IDLE; busy=0; new start required.

Verification
REQ-027 Bench SHALL use a behavioural EFB model with 0-3 cycle random ack delay returning byte = page*16+index (low 8 bits).
REQ-028 Reset, start, start_page=0x0002 -> exact write sequence of REQ-011/012/013 with page bytes 0x00,0x02; busy=1.
REQ-029 16 stb pulses spaced 4 cycles -> data 0x20..0x2F, one data_valid each, then close write 0x00 to 0x70.
REQ-030 stb held high continuously for a page -> exactly 16 data_valid pulses, never two consecutive cycles.
REQ-031 AUTOINC_EN defined, start_page=0x3FFF, 32 requests -> bytes 0xF0..0xFF then 0x00..0x0F, no second 0xB4 command; undefined -> busy=0 after 16, further stb yields nothing.
REQ-032 rst asserted during READ_BYTE with ack pending -> wb_cyc_o=0 next cycle, no data_valid; subsequent start to page 0x0001 delivers 0x10 first.
